// File: rtl/ucie_sb_tx_arb.sv
// rtl/ucie_sb_tx_arb.sv - round-robin sideband packet arbiter and LSB-first serializer
`timescale 1ns/1ps
module ucie_sb_tx_arb #(
  parameter int NUM_REQ = 2,
  parameter int PKT_W   = 64,
  parameter int GAP_UI  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     sbtx_data,
  output logic                     sbtx_clk_en,
  output logic                     busy,
  output logic [1:0]               gnt_id,
  output logic                     pkt_done
);

  localparam int MAX_W = (PKT_W > GAP_UI) ? PKT_W : GAP_UI;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_W - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PKT_W - 2);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_UI - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PKT_W-1:0]   sreg;
  logic [1:0]         ptr;
  logic               win_found;
  logic [1:0]         win_id;
  logic [PKT_W-1:0]   win_pkt;
  logic               grant_ok;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          win_found = 1'b1;
          win_id    = 2'(i);
        end
      end
    end
  end

  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == 2'(i)) win_pkt = req_pkt[i*PKT_W +: PKT_W];
    end
  end

  assign grant_ok = reset_n && sb_en && (state == IDLE) && win_found;
  assign busy     = (state != IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_ok && (win_id == 2'(i))) req_ready[i] = 1'b1;
    end
  end

  // Bit 0 goes out with the first SHIFT cycle, so the shifter holds the rest.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      ptr         <= 2'(NUM_REQ - 1);
      gnt_id      <= 2'd0;
      sbtx_clk_en <= 1'b0;
      sbtx_data   <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pkt_done <= 1'b0;
          if (grant_ok) begin
            state       <= SHIFT;
            cnt         <= '0;
            sreg        <= win_pkt >> 1;
            sbtx_data   <= win_pkt[0];
            sbtx_clk_en <= 1'b1;
            gnt_id      <= win_id;
            ptr         <= win_id;
          end
        end
        SHIFT: begin
          if (cnt == LAST_BIT) begin
            state       <= GAP;
            cnt         <= '0;
            sbtx_clk_en <= 1'b0;
            sbtx_data   <= 1'b0;
            pkt_done    <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            sbtx_data <= sreg[0];
            sreg      <= sreg >> 1;
            pkt_done  <= (cnt == PRE_LAST);
          end
        end
        GAP: begin
          if (cnt == LAST_GAP) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_sb_tx_arb.sv
// tb/tb_ucie_sb_tx_arb.sv - self-checking bench for ucie_sb_tx_arb
`timescale 1ns/1ps
module tb_ucie_sb_tx_arb;
  localparam int N = 2;
  localparam int W = 64;
  localparam int G = 32;
  localparam int NPKT = 250;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sb_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_pkt = '0;
  logic [N-1:0]   req_ready;
  logic           sbtx_data, sbtx_clk_en, busy, pkt_done;
  logic [1:0]     gnt_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ucie_sb_tx_arb #(.NUM_REQ(N), .PKT_W(W), .GAP_UI(G)) dut (
    .clk(clk), .reset_n(reset_n), .sb_en(sb_en), .req_valid(req_valid),
    .req_pkt(req_pkt), .req_ready(req_ready), .sbtx_data(sbtx_data),
    .sbtx_clk_en(sbtx_clk_en), .busy(busy), .gnt_id(gnt_id), .pkt_done(pkt_done)
  );

  typedef struct {
    logic        en;
    logic [1:0]  valid;
    logic [63:0] pkt0;
    logic [63:0] pkt1;
    logic [1:0]  ready;
    logic [1:0]  gnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Packed as {ready[1:0], busy, clk_en, data, done, gnt[1:0]}.
  task automatic expect_out(string tag, logic [1:0] rdy, logic b, logic en,
                            logic d, logic dn, logic [1:0] g);
    chk(tag, {56'd0, req_ready, busy, sbtx_clk_en, sbtx_data, pkt_done, gnt_id},
             {56'd0, rdy, b, en, d, dn, g});
  endtask

  task automatic run_pkt(string tag, logic [W-1:0] pkt, logic [1:0] g, int drop_at);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      req_pkt = {$urandom, $urandom, $urandom, $urandom};
      if (k == drop_at) sb_en = 1'b0;
      #2;
      expect_out({tag, "_bit"}, 2'b00, 1'b1, 1'b1, pkt[k], (k == W-1), g);
    end
    for (int k = 0; k < G; k++) begin
      @(negedge clk);
      req_pkt = {$urandom, $urandom, $urandom, $urandom};
      #2;
      expect_out({tag, "_gap"}, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, g);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(int p, logic [N-1:0] v);
    logic [N-1:0] r;
    int i;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      i = (p + k) % N;
      if (v[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  last_g;
    logic [63:0] p;
    logic [3:0]  q[$];
    logic [3:0]  e;
    logic [N-1:0] exp_rdy;
    int mptr, mg, idx, pkts, cyc, run_len, quiet;
    logic prev_en, seen_burst;

    tbl[0] = '{1'b0, 2'b11, 64'h0, 64'h0, 2'b00, 2'd0};
    tbl[1] = '{1'b1, 2'b00, 64'h0, 64'h0, 2'b00, 2'd0};
    tbl[2] = '{1'b1, 2'b01, 64'hA5A5_0000_FFFF_1234, 64'h0, 2'b01, 2'd0};
    tbl[3] = '{1'b1, 2'b11, 64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0BAD_F00D, 2'b10, 2'd1};
    tbl[4] = '{1'b1, 2'b11, 64'h8000_0000_0000_0001, 64'h0, 2'b01, 2'd0};
    tbl[5] = '{1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 2'b01, 2'd0};
    tbl[6] = '{1'b1, 2'b10, 64'h0, 64'hC3C3_3C3C_0F0F_F0F0, 2'b10, 2'd1};

    // Reset with requests pending: nothing may be granted.
    sb_en = 1'b1; req_valid = 2'b11; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    expect_out("reset_state", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1; sb_en = 1'b0; req_valid = '0;
    #2;
    expect_out("post_reset_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    last_g = 2'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sb_en = tbl[i].en; req_valid = tbl[i].valid; req_pkt = {tbl[i].pkt1, tbl[i].pkt0};
      #2;
      expect_out($sformatf("vec%0d_grant", i), tbl[i].ready, 1'b0, 1'b0, 1'b0, 1'b0, last_g);
      if (tbl[i].ready != 2'b00) begin
        last_g = tbl[i].gnt;
        run_pkt($sformatf("vec%0d", i), tbl[i].ready[0] ? tbl[i].pkt0 : tbl[i].pkt1,
                tbl[i].gnt, -1);
      end
    end

    // sb_en falls mid-packet: packet completes, grants resume at once on re-enable.
    @(negedge clk);
    sb_en = 1'b1; req_valid = 2'b01; p = 64'h0123_4567_89AB_CDEF; req_pkt = {64'h0, p};
    #2;
    expect_out("sben_grant", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    run_pkt("sben_drop", p, 2'd0, 10);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      expect_out("sben_low_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    @(negedge clk);
    sb_en = 1'b1; p = 64'hFEDC_BA98_7654_3210; req_pkt = {p, 64'h0};
    #2;
    expect_out("sben_regrant", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_pkt("sben_next", p, 2'd1, -1);

    // Reset during SHIFT cycle 20 truncates the packet.
    @(negedge clk);
    req_valid = 2'b01; p = 64'hAAAA_5555_F0F0_0F0F; req_pkt = {64'h0, p};
    #2;
    expect_out("rst_grant", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_pkt = {$urandom, $urandom, $urandom, $urandom};
      #2;
      expect_out("rst_prefix", 2'b00, 1'b1, 1'b1, p[k], 1'b0, 2'd0);
    end
    @(negedge clk);
    reset_n = 1'b0; req_valid = 2'b11;
    #2;
    chk("ready_in_reset", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = 2'b10; p = 64'h1357_9BDF_2468_ACE0; req_pkt = {p, 64'h0};
    #2;
    expect_out("rst_after", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_pkt("rst_pkt", p, 2'd1, -1);

    // Random traffic against a packet-level queue model.
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    mptr = N - 1; mg = 0; pkts = 0; cyc = 0;
    run_len = 0; quiet = 0; prev_en = 1'b0; seen_burst = 1'b0;
    while (pkts < NPKT && cyc < 40000) begin
      @(negedge clk);
      sb_en = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_pkt = {$urandom, $urandom, $urandom, $urandom};
      #2;
      cyc++;
      if (q.size() == 0) begin
        exp_rdy = sb_en ? rr_pick(mptr, req_valid) : '0;
        expect_out("rand_idle", exp_rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'(mg));
        if (exp_rdy != '0) begin
          idx = 0;
          for (int i = 0; i < N; i++) if (exp_rdy[i]) idx = i;
          p = req_pkt[idx*W +: W];
          for (int k = 0; k < W; k++) q.push_back({1'b1, 1'b1, p[k], (k == W-1)});
          for (int k = 0; k < G; k++) q.push_back(4'b1000);
          mptr = idx; mg = idx; pkts++;
        end
      end else begin
        e = q.pop_front();
        expect_out("rand_xfer", 2'b00, e[3], e[2], e[1], e[0], 2'(mg));
      end
      if (sbtx_clk_en) begin
        if (!prev_en && seen_burst) chk("rand_gap_min", {63'd0, quiet >= G + 1}, 64'd1);
        run_len++;
        quiet = 0;
        seen_burst = 1'b1;
      end else begin
        if (prev_en) chk("rand_burst_len", 64'(run_len), 64'(W));
        run_len = 0;
        quiet++;
      end
      prev_en = sbtx_clk_en;
    end
    chk("rand_progress", 64'(pkts), 64'(NPKT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ucie_sb_tx_arb.md
UCIE_SB_TX_ARB -- requirements
Module: ucie_sb_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, meaning number of packet requesters (legal range 2..4).
REQ-002 Parameter PKT_W, default 64, meaning sideband packet width in UI.
REQ-003 Parameter GAP_UI, default 32, meaning minimum quiet UI between packets.
REQ-004 Port clk  input  1  800 MHz sideband bit clock; one UI per cycle.
REQ-005 Port reset_n  input  1  synchronous, active-low reset.
REQ-006 Port sb_en  input  1  arbitration enable; low blocks new grants.
REQ-007 Port req_valid  input  NUM_REQ  per-requester packet valid.
REQ-008 Port req_pkt  input  NUM_REQ*PKT_W  per-requester packet; requester i occupies bits [i*PKT_W +: PKT_W].
REQ-009 Port req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-010 Port sbtx_data  output  1  serial data toward SBTX_DATA.
REQ-011 Port sbtx_clk_en  output  1  clock-gate enable producing SBTX_CLK pulses.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port gnt_id  output  2  index of requester owning the current or last packet.
REQ-014 Port pkt_done  output  1  one-cycle pulse on the last UI of a packet.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and GAP; the reset state is IDLE.
REQ-016 IDLE: when sb_en=1 and req_valid!=0, req_ready SHALL be driven combinationally one-hot to the round-robin winner in that same cycle; all other req_ready bits stay 0.
REQ-017 A transfer occurs when req_valid[i] and req_ready[i] are both high; the packet is captured into a PKT_W shift register and gnt_id is set to i; the next state is SHIFT.
REQ-018 req_ready SHALL be 0 in SHIFT, in GAP, and whenever sb_en=0.
REQ-019 Round-robin: the pointer SHALL hold the last granted index; search starts at pointer+1 modulo NUM_REQ; the pointer updates only on a transfer.
REQ-020 SHIFT SHALL last exactly PKT_W cycles; sbtx_clk_en=1 and sbtx_data=packet bit k in the k-th SHIFT cycle, LSB first (bit 0 in the first cycle).
REQ-021 pkt_done SHALL pulse high in SHIFT cycle PKT_W-1 only; the next state is GAP.
REQ-022 GAP SHALL last exactly GAP_UI cycles with sbtx_clk_en=0 and sbtx_data=0, then return to IDLE.
REQ-023 The minimum distance from the last clocked bit to the next first clocked bit is therefore GAP_UI+1 cycles (GAP plus one IDLE grant cycle).
REQ-024 The bit counter SHALL be ceil(log2(max(PKT_W,GAP_UI))) bits wide and reused for SHIFT and GAP; it clears on every state entry.
REQ-025 A deassertion of sb_en during SHIFT or GAP SHALL NOT abort the packet; it blocks only the next grant.
REQ-026 Changes in req_valid or req_pkt after capture SHALL NOT affect the packet in flight.
REQ-027 Outside SHIFT, sbtx_clk_en SHALL be 0 and sbtx_data SHALL be 0.

Reset
REQ-028 With reset_n=0 at a clk edge, the following SHALL hold from the next cycle: state=IDLE, counter=0, shift register=0, round-robin pointer=NUM_REQ-1 (so requester 0 wins first), gnt_id=0, sbtx_clk_en=0, sbtx_data=0, pkt_done=0, busy=0.
REQ-029 During reset, req_ready SHALL be 0 regardless of req_valid.
REQ-030 A reset asserted mid-SHIFT SHALL truncate the packet immediately; after release, no remnant bits are sent and arbitration restarts from the reset pointer.

Verification
REQ-031 Single packet: req_valid=01, req_pkt[63:0]=64'hA5A5_0000_FFFF_1234 -> req_ready[0] high for 1 cycle; 64 cycles of clk_en=1 with data LSB first (0,0,1,0,1,1,0,0...); pkt_done on cycle 64; 32 cycles quiet; busy low afterward.
REQ-032 Contention: req_valid=11 held continuously -> grant order 0,1,0,1; gnt_id toggles; the quiet gap between packets is exactly 33 cycles.
REQ-033 sb_en drop: sb_en falls in SHIFT cycle 10 -> all 64 bits are still sent and GAP completes; no req_ready while sb_en=0; a grant occurs in the first IDLE cycle after sb_en=1.
REQ-034 Mid-packet reset: reset_n=0 for 1 cycle at SHIFT cycle 20 -> sbtx_clk_en=0 on the following cycle; after release with req_valid=10, requester 1 wins, 64 full bits are sent, and no stale data appears.
REQ-035 Input churn: req_pkt changes every cycle after the handshake -> serialized bits match the value captured at the handshake.
REQ-036 Protocol check: over 1000 random packets, bound to the sideband interface assertions, there are zero violations of the 800 MHz and 32 UI gap checks.
